// File: rtl/pcie_tx_lane_os_gen.sv
// rtl/pcie_tx_lane_os_gen.sv - per-lane PCIe TX ordered-set generator with periodic SKP scheduler
// Emits TS1/TS2/SKP/FTS/EIOS sets and logical idle, one registered symbol per clock.
module pcie_tx_lane_os_gen #(
    parameter int          SKP_INTERVAL = 1180,
    parameter logic [7:0]  IDLE_BYTE    = 8'h00
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ReqValid,
    output logic       ReqReady,
    input  logic [2:0] ReqType,
    input  logic [7:0] ReqCount,
    input  logic [7:0] LinkNum,
    input  logic       LinkPad,
    input  logic [4:0] LaneNum,
    input  logic       LanePad,
    input  logic [7:0] NFts,
    input  logic [7:0] DataRate,
    input  logic [7:0] LinkCtrl,
    input  logic       SkpEnable,
    output logic [7:0] TxByte,
    output logic       TxControl,
    output logic       TxComma,
    output logic       TxOsActive,
    output logic       Busy
);

    localparam int CW = ($clog2(SKP_INTERVAL) > 11) ? $clog2(SKP_INTERVAL) : 11;
    localparam logic [CW-1:0] SKP_LAST = CW'(SKP_INTERVAL - 1);

    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;
    localparam logic [7:0] K_FTS = 8'h3C;
    localparam logic [7:0] K_IDL = 8'h7C;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] D_TS1 = 8'h4A;
    localparam logic [7:0] D_TS2 = 8'h45;

    localparam logic [2:0] T_TS1  = 3'd1;
    localparam logic [2:0] T_TS2  = 3'd2;
    localparam logic [2:0] T_SKP  = 3'd3;
    localparam logic [2:0] T_FTS  = 3'd4;
    localparam logic [2:0] T_EIOS = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_SKPINS = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_idx;
    logic [7:0]    r_rep;
    logic          r_resume;
    logic [2:0]    r_type;
    logic [7:0]    r_link;
    logic          r_link_pad;
    logic [4:0]    r_lane;
    logic          r_lane_pad;
    logic [7:0]    r_nfts;
    logic [7:0]    r_rate;
    logic [7:0]    r_ctrl;
    logic [CW-1:0] r_skp_cnt;
    logic          r_skp_pending;

    state_t        w_state_n;
    logic [3:0]    w_idx_n;
    logic [7:0]    w_rep_n;
    logic          w_resume_n;
    logic          w_load;
    logic          w_is_ts;
    logic          w_last_sym;
    logic          w_expire;
    logic          w_skp_due;
    logic          w_req_slot;
    logic          w_accept;
    logic          w_req_ok;
    logic [7:0]    w_rep_load;
    logic          w_enter_skp;

    logic [2:0]    w_type_n;
    logic [7:0]    w_link_n;
    logic          w_link_pad_n;
    logic [4:0]    w_lane_n;
    logic          w_lane_pad_n;
    logic [7:0]    w_nfts_n;
    logic [7:0]    w_rate_n;
    logic [7:0]    w_ctrl_n;

    logic [7:0]    w_byte;
    logic          w_k;
    logic          w_comma;
    logic          w_os;

    assign w_is_ts    = (r_type == T_TS1) || (r_type == T_TS2);
    assign w_last_sym = ((r_state == ST_SEND) && (r_idx == (w_is_ts ? 4'd15 : 4'd3))) ||
                        ((r_state == ST_SKPINS) && (r_idx == 4'd3));
    assign w_expire   = SkpEnable && (r_skp_cnt == SKP_LAST);
    assign w_skp_due  = r_skp_pending || w_expire;

    // A new request may only be taken where the stream would otherwise fall back to idle.
    assign w_req_slot = (r_state == ST_IDLE) ||
                        ((r_state == ST_SEND) && w_last_sym && (r_rep == 8'd0)) ||
                        ((r_state == ST_SKPINS) && w_last_sym && !r_resume);
    assign ReqReady   = w_req_slot && !w_skp_due;
    assign w_accept   = ReqValid && ReqReady;
    assign w_req_ok   = (ReqType >= T_TS1) && (ReqType <= T_EIOS);
    assign w_rep_load = (ReqCount == 8'd0) ? 8'd0 : ReqCount - 8'd1;

    always_comb begin
        w_state_n  = r_state;
        w_idx_n    = r_idx;
        w_rep_n    = r_rep;
        w_resume_n = r_resume;
        w_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_skp_due) begin
                    w_state_n  = ST_SKPINS;
                    w_idx_n    = 4'd0;
                    w_resume_n = 1'b0;
                end else if (w_accept && w_req_ok) begin
                    w_load    = 1'b1;
                    w_state_n = ST_SEND;
                    w_idx_n   = 4'd0;
                    w_rep_n   = w_rep_load;
                end
            end
            ST_SEND: begin
                if (!w_last_sym) begin
                    w_idx_n = r_idx + 4'd1;
                end else if (w_skp_due) begin
                    w_state_n  = ST_SKPINS;
                    w_idx_n    = 4'd0;
                    w_resume_n = (r_rep != 8'd0);
                end else if (r_rep != 8'd0) begin
                    w_idx_n = 4'd0;
                    w_rep_n = r_rep - 8'd1;
                end else if (w_accept && w_req_ok) begin
                    w_load  = 1'b1;
                    w_idx_n = 4'd0;
                    w_rep_n = w_rep_load;
                end else begin
                    w_state_n = ST_IDLE;
                    w_idx_n   = 4'd0;
                end
            end
            ST_SKPINS: begin
                if (!w_last_sym) begin
                    w_idx_n = r_idx + 4'd1;
                end else if (r_resume) begin
                    w_state_n  = ST_SEND;
                    w_idx_n    = 4'd0;
                    w_rep_n    = r_rep - 8'd1;
                    w_resume_n = 1'b0;
                end else if (w_accept && w_req_ok) begin
                    w_load    = 1'b1;
                    w_state_n = ST_SEND;
                    w_idx_n   = 4'd0;
                    w_rep_n   = w_rep_load;
                end else begin
                    w_state_n = ST_IDLE;
                    w_idx_n   = 4'd0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_idx_n   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_type_n     = w_load ? ReqType  : r_type;
        w_link_n     = w_load ? LinkNum  : r_link;
        w_link_pad_n = w_load ? LinkPad  : r_link_pad;
        w_lane_n     = w_load ? LaneNum  : r_lane;
        w_lane_pad_n = w_load ? LanePad  : r_lane_pad;
        w_nfts_n     = w_load ? NFts     : r_nfts;
        w_rate_n     = w_load ? DataRate : r_rate;
        w_ctrl_n     = w_load ? LinkCtrl : r_ctrl;
    end

    // Symbol for the state being entered, so outputs register with one cycle of latency.
    always_comb begin
        w_byte  = IDLE_BYTE;
        w_k     = 1'b0;
        w_comma = 1'b0;
        w_os    = 1'b0;
        if (w_state_n == ST_SKPINS) begin
            w_os    = 1'b1;
            w_k     = 1'b1;
            w_comma = (w_idx_n == 4'd0);
            w_byte  = (w_idx_n == 4'd0) ? K_COM : K_SKP;
        end else if (w_state_n == ST_SEND) begin
            w_os = 1'b1;
            if (w_idx_n == 4'd0) begin
                w_byte  = K_COM;
                w_k     = 1'b1;
                w_comma = 1'b1;
            end else if ((w_type_n == T_TS1) || (w_type_n == T_TS2)) begin
                case (w_idx_n)
                    4'd1: begin
                        w_byte = w_link_pad_n ? K_PAD : w_link_n;
                        w_k    = w_link_pad_n;
                    end
                    4'd2: begin
                        w_byte = w_lane_pad_n ? K_PAD : {3'b000, w_lane_n};
                        w_k    = w_lane_pad_n;
                    end
                    4'd3:    w_byte = w_nfts_n;
                    4'd4:    w_byte = w_rate_n;
                    4'd5:    w_byte = w_ctrl_n;
                    default: w_byte = (w_type_n == T_TS1) ? D_TS1 : D_TS2;
                endcase
            end else begin
                w_k = 1'b1;
                case (w_type_n)
                    T_SKP:   w_byte = K_SKP;
                    T_FTS:   w_byte = K_FTS;
                    default: w_byte = K_IDL;
                endcase
            end
        end
    end

    assign w_enter_skp = (w_state_n == ST_SKPINS) && (r_state != ST_SKPINS);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= 4'd0;
            r_rep         <= 8'd0;
            r_resume      <= 1'b0;
            r_type        <= 3'd0;
            r_link        <= 8'd0;
            r_link_pad    <= 1'b0;
            r_lane        <= 5'd0;
            r_lane_pad    <= 1'b0;
            r_nfts        <= 8'd0;
            r_rate        <= 8'd0;
            r_ctrl        <= 8'd0;
            r_skp_cnt     <= '0;
            r_skp_pending <= 1'b0;
            TxByte        <= IDLE_BYTE;
            TxControl     <= 1'b0;
            TxComma       <= 1'b0;
            TxOsActive    <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_idx      <= w_idx_n;
            r_rep      <= w_rep_n;
            r_resume   <= w_resume_n;
            r_type     <= w_type_n;
            r_link     <= w_link_n;
            r_link_pad <= w_link_pad_n;
            r_lane     <= w_lane_n;
            r_lane_pad <= w_lane_pad_n;
            r_nfts     <= w_nfts_n;
            r_rate     <= w_rate_n;
            r_ctrl     <= w_ctrl_n;
            if (SkpEnable) begin
                r_skp_cnt <= (r_skp_cnt == SKP_LAST) ? '0 : r_skp_cnt + 1'b1;
            end
            // Entering SKPINS consumes the pending request, absorbing any same-cycle expiry.
            if (w_enter_skp) begin
                r_skp_pending <= 1'b0;
            end else if (w_expire) begin
                r_skp_pending <= 1'b1;
            end
            TxByte     <= w_byte;
            TxControl  <= w_k;
            TxComma    <= w_comma;
            TxOsActive <= w_os;
            Busy       <= (w_state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_pcie_tx_lane_os_gen.sv
// tb/tb_pcie_tx_lane_os_gen.sv - scoreboard bench for pcie_tx_lane_os_gen
module tb_pcie_tx_lane_os_gen;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       ReqValid = 1'b0;
    logic       ReqReady;
    logic [2:0] ReqType = 3'd0;
    logic [7:0] ReqCount = 8'd0;
    logic [7:0] LinkNum = 8'd0;
    logic       LinkPad = 1'b0;
    logic [4:0] LaneNum = 5'd0;
    logic       LanePad = 1'b0;
    logic [7:0] NFts = 8'd0;
    logic [7:0] DataRate = 8'd0;
    logic [7:0] LinkCtrl = 8'd0;
    logic       SkpEnable = 1'b0;
    logic [7:0] TxByte;
    logic       TxControl;
    logic       TxComma;
    logic       TxOsActive;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [11:0] q[$];

    localparam logic [11:0] IDLE_VEC = 12'h000;

    pcie_tx_lane_os_gen #(.SKP_INTERVAL(40), .IDLE_BYTE(8'h00)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqType(ReqType), .ReqCount(ReqCount), .LinkNum(LinkNum), .LinkPad(LinkPad),
        .LaneNum(LaneNum), .LanePad(LanePad), .NFts(NFts), .DataRate(DataRate),
        .LinkCtrl(LinkCtrl), .SkpEnable(SkpEnable), .TxByte(TxByte), .TxControl(TxControl),
        .TxComma(TxComma), .TxOsActive(TxOsActive), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        logic [11:0] exp;
        @(posedge Clk);
        #1;
        cyc++;
        exp = (q.size() > 0) ? q.pop_front() : IDLE_VEC;
        chk(tag, {20'd0, TxByte, TxControl, TxComma, TxOsActive, Busy}, {20'd0, exp});
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic push_sym(input logic [7:0] b, input logic k, input logic c);
        q.push_back({b, k, c, 1'b1, 1'b1});
    endtask

    task automatic push_k4(input logic [7:0] b);
        push_sym(8'hBC, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push_sym(b, 1'b1, 1'b0);
    endtask

    task automatic push_ts(input logic [7:0] id, input logic [7:0] link, input logic lpad,
                           input logic [4:0] lane, input logic npad, input logic [7:0] nfts,
                           input logic [7:0] rate, input logic [7:0] ctrl);
        push_sym(8'hBC, 1'b1, 1'b1);
        if (lpad) push_sym(8'hF7, 1'b1, 1'b0); else push_sym(link, 1'b0, 1'b0);
        if (npad) push_sym(8'hF7, 1'b1, 1'b0); else push_sym({3'b000, lane}, 1'b0, 1'b0);
        push_sym(nfts, 1'b0, 1'b0);
        push_sym(rate, 1'b0, 1'b0);
        push_sym(ctrl, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) push_sym(id, 1'b0, 1'b0);
    endtask

    task automatic drive(input logic [2:0] t, input logic [7:0] cnt, input logic [7:0] link,
                         input logic lpad, input logic [4:0] lane, input logic npad,
                         input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctrl);
        ReqType  = t;
        ReqCount = cnt;
        LinkNum  = link;
        LinkPad  = lpad;
        LaneNum  = lane;
        LanePad  = npad;
        NFts     = nfts;
        DataRate = rate;
        LinkCtrl = ctrl;
        ReqValid = 1'b1;
    endtask

    task automatic accept(input string tag);
        chk({tag, "_ready"}, {31'd0, ReqReady}, 32'd1);
        tick(tag);
        ReqValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        ticks("reset", 2);
        chk("reset_ready", {31'd0, ReqReady}, 32'd1);
        Reset = 1'b0;
        ticks("idle", 2);

        drive(3'd1, 8'd1, 8'd0, 1'b1, 5'd0, 1'b1, 8'h1F, 8'h02, 8'h00);
        push_ts(8'h4A, 8'd0, 1'b1, 5'd0, 1'b1, 8'h1F, 8'h02, 8'h00);
        accept("ts1_pad");
        ticks("ts1_pad", 15);
        ticks("ts1_idle", 3);

        drive(3'd2, 8'd3, 8'd3, 1'b0, 5'd5, 1'b0, 8'h10, 8'h02, 8'h00);
        for (int r = 0; r < 3; r++) push_ts(8'h45, 8'd3, 1'b0, 5'd5, 1'b0, 8'h10, 8'h02, 8'h00);
        accept("ts2_x3");
        chk("ts2_ready", {31'd0, ReqReady}, 32'd0);
        for (int i = 1; i < 48; i++) begin
            tick("ts2_x3");
            chk("ts2_ready", {31'd0, ReqReady}, (i == 47) ? 32'd1 : 32'd0);
        end
        ticks("ts2_idle", 3);

        drive(3'd4, 8'd0, 8'd0, 1'b0, 5'd0, 1'b0, 8'd0, 8'd0, 8'd0);
        push_k4(8'h3C);
        accept("fts_cnt0");
        ticks("fts_cnt0", 3);
        ticks("fts_idle", 2);

        drive(3'd5, 8'd1, 8'd0, 1'b0, 5'd0, 1'b0, 8'd0, 8'd0, 8'd0);
        push_k4(8'h7C);
        accept("eios");
        ticks("eios", 3);
        ticks("eios_idle", 2);

        SkpEnable = 1'b1;
        drive(3'd1, 8'd4, 8'd1, 1'b0, 5'd2, 1'b0, 8'h20, 8'h02, 8'h00);
        for (int r = 0; r < 3; r++) push_ts(8'h4A, 8'd1, 1'b0, 5'd2, 1'b0, 8'h20, 8'h02, 8'h00);
        push_k4(8'h1C);
        push_ts(8'h4A, 8'd1, 1'b0, 5'd2, 1'b0, 8'h20, 8'h02, 8'h00);
        accept("skp_b2b");
        ticks("skp_b2b", 67);
        ticks("skp_b2b_idle", 11);

        drive(3'd5, 8'd1, 8'd0, 1'b0, 5'd0, 1'b0, 8'd0, 8'd0, 8'd0);
        chk("expire_ready", {31'd0, ReqReady}, 32'd0);
        push_k4(8'h1C);
        push_k4(8'h7C);
        ticks("skp_first", 3);
        chk("skpins_ready", {31'd0, ReqReady}, 32'd0);
        tick("skp_first");
        accept("req_after_skp");
        ticks("req_after_skp", 3);
        SkpEnable = 1'b0;
        ticks("post_skp_idle", 3);

        drive(3'd1, 8'd1, 8'd7, 1'b0, 5'd1, 1'b0, 8'h05, 8'h02, 8'h00);
        push_ts(8'h4A, 8'd7, 1'b0, 5'd1, 1'b0, 8'h05, 8'h02, 8'h00);
        accept("ts1_rst");
        ticks("ts1_rst", 7);
        Reset = 1'b1;
        #1;
        chk("async_reset", {20'd0, TxByte, TxControl, TxComma, TxOsActive, Busy}, {20'd0, IDLE_VEC});
        q.delete();
        ticks("in_reset", 2);
        Reset = 1'b0;
        SkpEnable = 1'b1;
        ticks("cnt_restart", 39);
        push_k4(8'h1C);
        ticks("cnt_restart_skp", 4);
        SkpEnable = 1'b0;

        drive(3'd6, 8'd2, 8'd0, 1'b0, 5'd0, 1'b0, 8'd0, 8'd0, 8'd0);
        accept("invalid_type");
        ticks("invalid_idle", 20);
        chk("queue_empty", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_tx_lane_os_gen.md
Name: pcie_tx_lane_os_gen

Overview:
Transmit-side, per-lane ordered-set generator for the PCIe link. It produces the symbol stream that the lane display/decode logic consumes on the receive side: TS1, TS2, SKP, FTS and EIOS ordered sets, plus logical idle. It also runs the periodic SKP scheduler. The output is one byte per Clk with a K-symbol flag, and feeds the lane's scrambler/8b10b encoder.

Parameters:
SKP_INTERVAL, 1180, symbol cycles between SKP insertions (minimum 8).
IDLE_BYTE, 8'h00, data byte driven in logical idle.

Ports:
Clk  in  1  lane symbol clock
Reset  in  1  asynchronous active-high reset
ReqValid  in  1  ordered-set request valid
ReqReady  out  1  request accepted on ReqValid&&ReqReady at posedge Clk
ReqType  in  3  1=TS1 2=TS2 3=SKP 4=FTS 5=EIOS; 0,6,7 invalid
ReqCount  in  8  repetitions, back-to-back; 0 is treated as 1
LinkNum  in  8  TS link number
LinkPad  in  1  send PAD (K23.7) instead of LinkNum
LaneNum  in  5  TS lane number (zero-extended to 8)
LanePad  in  1  send PAD instead of LaneNum
NFts  in  8  TS N_FTS field
DataRate  in  8  TS data-rate field
LinkCtrl  in  8  TS training-control field
SkpEnable  in  1  enables the SKP scheduler
TxByte  out  8  transmit symbol
TxControl  out  1  TxByte is a K symbol
TxComma  out  1  TxByte is the COM that opens an ordered set
TxOsActive  out  1  symbol belongs to an ordered set (scrambler bypass/reset hint)
Busy  out  1  generator is not in IDLE

Behaviour:
- All outputs except ReqReady are registered. Reset drives TxByte=IDLE_BYTE and TxControl=TxComma=TxOsActive=Busy=0. It clears the state, the SKP counter and SkpPending immediately, including mid-set; no partial set resumes.
- Request fields are captured on acceptance. COM appears on TxByte in the next cycle (latency 1).
- Symbol encodings: COM=K28.5 (BC), SKP=K28.0 (1C), FTS=K28.1 (3C), IDL=K28.3 (7C), PAD=K23.7 (F7), TS1 ID=D10.2 (4A), TS2 ID=D5.2 (45).
- TS1/TS2 (16 symbols), in order: COM, Link, Lane, N_FTS, DataRate, LinkCtrl, then 10 ID symbols. TxControl=1 on COM and on any PAD field only.
- SKP: COM, SKP x3. FTS: COM, FTS x3. EIOS: COM, IDL x3. All four symbols have TxControl=1.
- TxComma=1 only on COM. TxOsActive=1 on every symbol of a set.
- States and transitions:
  - IDLE: drives logical idle.
  - SEND: symbol index 0..15 (TS) or 0..3 (others), plus a repetition counter.
  - SKPINS: 4-symbol scheduler SKP.
  - IDLE -> SKPINS if SkpPending; else -> SEND on acceptance.
  - At each set boundary (last symbol of a set): if SkpPending -> SKPINS; else next repetition; else IDLE or back-to-back accept.
  - SKPINS returns to SEND (remaining repetitions) or IDLE.
- ReqReady = (state==IDLE || last symbol of last repetition) && !SkpPending && !(scheduler expiring this cycle). Back-to-back sets therefore have zero gap.
- Invalid ReqType: request is accepted and dropped; the stream stays idle, with no error output.
- SKP scheduler:
  - 11+ bit counter increments every Clk while SkpEnable=1.
  - At SKP_INTERVAL-1 it sets SkpPending and wraps to 0.
  - SkpPending clears when SKPINS emits its COM.
  - Counter holds when SkpEnable=0; SkpPending is not cleared by SkpEnable falling.
  - A second expiry while already pending is absorbed: one SKP, no queue.
- Requested SKP (ReqType=3) behaves as a normal set and does not reset the scheduler counter.
- Simultaneous expiry and ReqValid in IDLE: SKP wins, ReqReady stays 0 and the request waits.
- SKPs never split a set; they insert only at boundaries, including between repetitions.

Test Plan:
- Reset, then TS1 with LinkPad=1, LanePad=1, NFts=8'h1F, DataRate=8'h02, LinkCtrl=0, Count=1 -> next cycle BC(K) F7(K) F7(K) 1F 02 00 4A x10. TxComma only on BC. Then idle 00 with Busy=0.
- TS2 with Link=3, Lane=5, Count=3 -> 48 contiguous symbols with COM at offsets 0, 16, 32. Symbols 6-15 of each set are 45. ReqReady=1 only on symbol 47.
- FTS with Count=0 -> exactly one BC 3C 3C 3C, all K. EIOS -> BC 7C 7C 7C.
- SKP_INTERVAL=40, SkpEnable=1, back-to-back TS1 x4 -> BC 1C 1C 1C inserted at the first set boundary after cycle 39. No TS is split, and the TS count stays 4.
- ReqValid held high in IDLE in the same cycle the scheduler expires -> SKP emitted first; the request is accepted on the SKP's last symbol and its COM follows immediately.
- Reset asserted at TS symbol 7 -> outputs go to reset values asynchronously. After release: idle, SkpPending=0, counter restarts from 0. ReqType=6 -> accepted, no ordered set emitted.
